// File: rtl/axi_tensor_wr.sv
// AXI4 write master (AW/W/B) for tensorcore result write-back: one burst at a time, data buffered in a small FIFO.
// Optional build macro AXI_WR_RESP_CHECK_EN enables the sticky bad-response flag on axi_wr_err.
`timescale 1ns/1ps
module axi_tensor_wr #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [31:0]             axi_wr_BASE,
  input  logic [5:0]              axi_wr_burst_num,
  input  logic [2:0]              axi_wr_burst_size,
  input  logic                    axi_wr_request_valid,
  output logic                    axi_wr_request_ready,
  input  logic [DATA_WIDTH-1:0]   axi_wr_data,
  input  logic                    axi_wr_data_valid,
  output logic                    axi_wr_data_ready,
  output logic                    axi_wr_finish,
  output logic [31:0]             axi_wr_beat_id,
  output logic                    axi_wr_busy,
  output logic                    axi_wr_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic [2:0]            awsize_q;
  logic [7:0]            in_cnt;
  logic [7:0]            out_cnt;
  logic [31:0]           beat_id_q;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty, fifo_full;
  logic                  req_fire, push, pop, last_beat;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign last_beat  = (out_cnt == awlen_q);

  // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt            = state;
    axi_wr_request_ready = 1'b0;
    m_axi_awvalid        = 1'b0;
    m_axi_wvalid         = 1'b0;
    m_axi_bready         = 1'b0;
    axi_wr_data_ready    = 1'b0;
    unique case (state)
      S_IDLE: begin
        axi_wr_request_ready = 1'b1;
        if (axi_wr_request_valid) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        m_axi_awvalid     = 1'b1;
        axi_wr_data_ready = !fifo_full && (in_cnt <= awlen_q);
        if (m_axi_awready) state_nxt = S_DATA;
      end
      S_DATA: begin
        m_axi_wvalid      = !fifo_empty;
        axi_wr_data_ready = !fifo_full && (in_cnt <= awlen_q);
        if (!fifo_empty && m_axi_wready && last_beat) state_nxt = S_RESP;
      end
      S_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_fire = axi_wr_request_valid && axi_wr_request_ready;
  assign push     = axi_wr_data_valid && axi_wr_data_ready;
  assign pop      = m_axi_wvalid && m_axi_wready;

  // Data-side outputs are forced to zero whenever no beat is presented, so reset and idle look clean.
  assign m_axi_wdata   = m_axi_wvalid ? fifo_mem[rd_ptr] : '0;
  assign m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
  assign m_axi_wlast   = m_axi_wvalid && last_beat;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = awsize_q;
  assign m_axi_awburst = 2'b01;
  assign axi_wr_finish = (state == S_RESP) && m_axi_bvalid;
  assign axi_wr_beat_id = beat_id_q;
  assign axi_wr_busy   = (state != S_IDLE);

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      beat_id_q <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (req_fire) begin
        awaddr_q  <= ADDR_WIDTH'(axi_wr_BASE);
        awlen_q   <= {2'b00, axi_wr_burst_num};
        awsize_q  <= axi_wr_burst_size;
        in_cnt    <= '0;
        out_cnt   <= '0;
        beat_id_q <= '0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        in_cnt <= in_cnt + 8'd1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        out_cnt   <= out_cnt + 8'd1;
        beat_id_q <= beat_id_q + 32'd1;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: the buffer storage has no reset; resetting the pointers and count already makes it empty.
  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr] <= axi_wr_data;
  end

`ifdef AXI_WR_RESP_CHECK_EN
  always_ff @(posedge aclk) begin
    if (areset)                                         axi_wr_err <= 1'b0;
    else if (req_fire)                                  axi_wr_err <= 1'b0;
    else if (m_axi_bready && m_axi_bvalid && (m_axi_bresp != 2'b00)) axi_wr_err <= 1'b1;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^m_axi_bresp;
  assign axi_wr_err   = 1'b0;
`endif

endmodule

// File: tb/tb_axi_tensor_wr.sv
// Self-checking bench for axi_tensor_wr: queue-based burst model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_axi_tensor_wr;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 256;
  localparam int FIFO_DEPTH = 4;
  localparam int STRB_W     = DATA_WIDTH / 8;
`ifdef AXI_WR_RESP_CHECK_EN
  localparam bit RESP_CHK = 1'b1;
`else
  localparam bit RESP_CHK = 1'b0;
`endif

  typedef logic [DATA_WIDTH-1:0] beat_t;

  logic                  aclk = 1'b0;
  logic                  areset = 1'b1;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready = 1'b0;
  beat_t                 m_axi_wdata;
  logic [STRB_W-1:0]     m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready = 1'b0;
  logic [1:0]            m_axi_bresp = 2'b00;
  logic                  m_axi_bvalid = 1'b0;
  logic                  m_axi_bready;
  logic [31:0]           axi_wr_BASE = '0;
  logic [5:0]            axi_wr_burst_num = '0;
  logic [2:0]            axi_wr_burst_size = '0;
  logic                  axi_wr_request_valid = 1'b0;
  logic                  axi_wr_request_ready;
  beat_t                 axi_wr_data = '0;
  logic                  axi_wr_data_valid = 1'b0;
  logic                  axi_wr_data_ready;
  logic                  axi_wr_finish;
  logic [31:0]           axi_wr_beat_id;
  logic                  axi_wr_busy;
  logic                  axi_wr_err;

  always #5 aclk = ~aclk;

  axi_tensor_wr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .axi_wr_BASE(axi_wr_BASE), .axi_wr_burst_num(axi_wr_burst_num), .axi_wr_burst_size(axi_wr_burst_size),
    .axi_wr_request_valid(axi_wr_request_valid), .axi_wr_request_ready(axi_wr_request_ready),
    .axi_wr_data(axi_wr_data), .axi_wr_data_valid(axi_wr_data_valid), .axi_wr_data_ready(axi_wr_data_ready),
    .axi_wr_finish(axi_wr_finish), .axi_wr_beat_id(axi_wr_beat_id), .axi_wr_busy(axi_wr_busy),
    .axi_wr_err(axi_wr_err)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input beat_t act, input beat_t exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Stimulus configuration and the tensorcore-side data source.
  beat_t src_q[$];
  int    aw_delay = 0, b_delay = 0, aw_wait = 0, b_wait = 0;
  bit    wready_toggle = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  // Behavioural model: burst bookkeeping with a queue standing in for the buffered beats.
  bit         chk_en = 1'b0;
  bit         m_active = 1'b0, m_aw_done = 1'b0, m_err = 1'b0;
  int         m_len = 0, m_in = 0, m_out = 0;
  logic [31:0] m_base = '0;
  logic [2:0] m_size = '0;
  beat_t      m_q[$];

  // Observation counters used by the directed literal checks.
  int    cyc = 0, w_hs_count = 0, wlast_count = 0, finish_count = 0, accept_count = 0;
  int    pre_aw_pushes = 0, finish_cyc = 0, accept_cyc = 0;
  beat_t last_wdata = '0;
  logic [31:0] last_awaddr = '0;
  logic [7:0]  last_awlen = '0;
  logic [2:0]  last_awsize = '0;

  always @(negedge aclk) begin : compare
    bit resp, e_awv, e_drdy, e_wv;
    logic [STRB_W-1:0] all_ones;
    all_ones = '1;
    cyc++;
    resp   = m_active && (m_out == m_len + 1);
    e_awv  = m_active && !m_aw_done;
    e_drdy = m_active && !resp && (m_q.size() < FIFO_DEPTH) && (m_in <= m_len);
    e_wv   = m_active && m_aw_done && !resp && (m_q.size() > 0);
    if (chk_en && !areset) begin
      check("request_ready", axi_wr_request_ready, !m_active);
      check("busy", axi_wr_busy, m_active);
      check("awvalid", m_axi_awvalid, e_awv);
      if (e_awv) begin
        check("awaddr", m_axi_awaddr, m_base);
        check("awlen", m_axi_awlen, m_len);
        check("awsize", m_axi_awsize, m_size);
      end
      check("awburst", m_axi_awburst, 2'b01);
      check("data_ready", axi_wr_data_ready, e_drdy);
      check("wvalid", m_axi_wvalid, e_wv);
      if (e_wv) begin
        check("wdata", m_axi_wdata, m_q[0]);
        check("wstrb", m_axi_wstrb, all_ones);
        check("wlast", m_axi_wlast, m_out == m_len);
      end
      check("bready", m_axi_bready, resp);
      check("finish", axi_wr_finish, resp && m_axi_bvalid);
      check("beat_id", axi_wr_beat_id, m_out);
      check("err", axi_wr_err, m_err);

      if (m_axi_awvalid && m_axi_awready) begin
        last_awaddr = m_axi_awaddr; last_awlen = m_axi_awlen; last_awsize = m_axi_awsize;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs_count++;
        last_wdata = m_axi_wdata;
        if (m_axi_wlast) wlast_count++;
      end
      if (axi_wr_finish) begin finish_count++; finish_cyc = cyc; end
      if (axi_wr_request_valid && axi_wr_request_ready) begin accept_count++; accept_cyc = cyc; end
      if (axi_wr_data_valid && axi_wr_data_ready && !m_aw_done) pre_aw_pushes++;
    end
    if (areset) begin
      m_active = 1'b0; m_aw_done = 1'b0; m_err = 1'b0;
      m_len = 0; m_in = 0; m_out = 0; m_base = '0; m_size = '0;
      m_q.delete();
    end else if (chk_en) begin
      if (!m_active) begin
        if (axi_wr_request_valid) begin
          m_active = 1'b1; m_aw_done = 1'b0; m_err = 1'b0;
          m_base = axi_wr_BASE; m_len = int'(axi_wr_burst_num); m_size = axi_wr_burst_size;
          m_in = 0; m_out = 0;
          m_q.delete();
        end
      end else begin
        if (e_awv && m_axi_awready) m_aw_done = 1'b1;
        if (e_wv && m_axi_wready) begin void'(m_q.pop_front()); m_out++; end
        if (e_drdy && axi_wr_data_valid) begin m_q.push_back(axi_wr_data); m_in++; end
        if (resp && m_axi_bvalid) begin
          m_active = 1'b0;
          if (RESP_CHK && m_axi_bresp != 2'b00) m_err = 1'b1;
        end
      end
    end
  end

  // One clock of stimulus: sample handshakes mid-cycle, then drive all inputs 1 ns after the edge.
  task automatic tick();
    bit d_hs, r_hs;
    @(negedge aclk);
    d_hs = axi_wr_data_valid && axi_wr_data_ready && !areset;
    r_hs = axi_wr_request_valid && axi_wr_request_ready && !areset;
    @(posedge aclk);
    #1;
    if (d_hs && src_q.size() > 0) void'(src_q.pop_front());
    if (r_hs) axi_wr_request_valid = 1'b0;
    axi_wr_data_valid = (src_q.size() > 0);
    axi_wr_data       = (src_q.size() > 0) ? src_q[0] : '0;
    if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
    else begin m_axi_awready = 1'b0; aw_wait = 0; end
    m_axi_wready = wready_toggle ? !m_axi_wready : 1'b1;
    if (m_axi_bready) begin
      m_axi_bvalid = (b_wait >= b_delay); b_wait++;
      m_axi_bresp  = m_axi_bvalid ? bresp_cfg : 2'b00;
    end else begin
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; b_wait = 0;
    end
  endtask

  task automatic request(input logic [31:0] base, input logic [5:0] num, input logic [2:0] size);
    axi_wr_BASE = base; axi_wr_burst_num = num; axi_wr_burst_size = size;
    axi_wr_request_valid = 1'b1;
  endtask

  task automatic clear_counters();
    w_hs_count = 0; wlast_count = 0; finish_count = 0; accept_count = 0; pre_aw_pushes = 0;
  endtask

  task automatic wait_finish(input int target, input string name);
    for (int i = 0; i < 400 && finish_count < target; i++) tick();
    check(name, finish_count >= target, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awaddr"}, m_axi_awaddr, 0);
    check({tag, "_awlen"}, m_axi_awlen, 0);
    check({tag, "_awsize"}, m_axi_awsize, 0);
    check({tag, "_awburst"}, m_axi_awburst, 2'b01);
    check({tag, "_awvalid"}, m_axi_awvalid, 0);
    check({tag, "_wvalid"}, m_axi_wvalid, 0);
    check({tag, "_wdata"}, m_axi_wdata, 0);
    check({tag, "_wstrb"}, m_axi_wstrb, 0);
    check({tag, "_wlast"}, m_axi_wlast, 0);
    check({tag, "_bready"}, m_axi_bready, 0);
    check({tag, "_request_ready"}, axi_wr_request_ready, 1);
    check({tag, "_data_ready"}, axi_wr_data_ready, 0);
    check({tag, "_finish"}, axi_wr_finish, 0);
    check({tag, "_beat_id"}, axi_wr_beat_id, 0);
    check({tag, "_busy"}, axi_wr_busy, 0);
    check({tag, "_err"}, axi_wr_err, 0);
  endtask

  initial begin
    beat_t pat;
    areset = 1'b1;
    repeat (3) tick();
    areset = 1'b0;
    chk_en = 1'b1;
    check_reset_outputs("reset");

    // Single beat.
    clear_counters();
    pat = {32{8'hA5}};
    src_q.push_back(pat);
    request(32'h0000_1000, 6'd0, 3'd5);
    wait_finish(1, "t1_finish_seen");
    check("t1_awaddr", last_awaddr, 32'h1000);
    check("t1_awlen", last_awlen, 0);
    check("t1_awsize", last_awsize, 5);
    check("t1_w_beats", w_hs_count, 1);
    check("t1_wlast_count", wlast_count, 1);
    check("t1_wdata", last_wdata, pat);
    check("t1_beat_id", axi_wr_beat_id, 1);
    tick();
    check("t1_finish_one_cycle", finish_count, 1);

    // 16 beats with wready toggling each cycle.
    clear_counters();
    wready_toggle = 1'b1;
    for (int i = 1; i <= 16; i++) src_q.push_back(beat_t'(i) | (beat_t'(i) << 200));
    request(32'h0000_8000, 6'd15, 3'd5);
    wait_finish(1, "t2_finish_seen");
    check("t2_awlen", last_awlen, 15);
    check("t2_w_beats", w_hs_count, 16);
    check("t2_wlast_count", wlast_count, 1);
    check("t2_last_wdata", last_wdata, beat_t'(16) | (beat_t'(16) << 200));
    check("t2_beat_id", axi_wr_beat_id, 16);
    wready_toggle = 1'b0;

    // AW held off for 10 cycles while the source keeps offering data.
    clear_counters();
    aw_delay = 10;
    for (int i = 0; i < 8; i++) src_q.push_back(beat_t'(32'hC0DE_0000 + i));
    request(32'h0000_2000, 6'd7, 3'd4);
    wait_finish(1, "t3_finish_seen");
    check("t3_pre_aw_pushes", pre_aw_pushes, 4);
    check("t3_awaddr", last_awaddr, 32'h2000);
    check("t3_awlen", last_awlen, 7);
    check("t3_w_beats", w_hs_count, 8);
    check("t3_beat_id", axi_wr_beat_id, 8);
    aw_delay = 0;

    // Slow B, with the next request already waiting during RESP.
    clear_counters();
    b_delay = 5;
    src_q.push_back(beat_t'(32'h1111));
    src_q.push_back(beat_t'(32'h2222));
    request(32'h0000_3000, 6'd1, 3'd5);
    for (int i = 0; i < 100 && !m_axi_bready; i++) tick();
    check("t4_reached_resp", m_axi_bready, 1);
    src_q.push_back(beat_t'(32'h3333));
    request(32'h0000_3100, 6'd0, 3'd5);
    for (int i = 0; i < 100 && accept_count < 2; i++) tick();
    check("t4_second_accept", accept_count, 2);
    check("t4_accept_after_finish", accept_cyc, finish_cyc + 1);
    wait_finish(2, "t4_both_finished");
    check("t4_awaddr", last_awaddr, 32'h3100);
    check("t4_last_wdata", last_wdata, beat_t'(32'h3333));
    b_delay = 0;

    // Error response.
    clear_counters();
    bresp_cfg = 2'b10;
    src_q.push_back(beat_t'(32'h4444));
    request(32'h0000_4000, 6'd0, 3'd5);
    wait_finish(1, "t5_finish_seen");
    check("t5_err_after_bad_b", axi_wr_err, RESP_CHK);
    bresp_cfg = 2'b00;

    // Reset in the middle of an 8-beat burst, then a clean 2-beat burst.
    clear_counters();
    for (int i = 0; i < 8; i++) src_q.push_back(beat_t'(32'h5000 + i));
    request(32'h0000_5000, 6'd7, 3'd5);
    for (int i = 0; i < 50 && accept_count < 1; i++) tick();
    check("t6_accepted", accept_count, 1);
    check("t6_err_cleared_on_accept", axi_wr_err, 0);
    for (int i = 0; i < 100 && w_hs_count < 3; i++) tick();
    check("t6_three_beats", w_hs_count, 3);
    areset = 1'b1;
    src_q.delete();
    axi_wr_data_valid = 1'b0;
    axi_wr_request_valid = 1'b0;
    tick();
    areset = 1'b0;
    aw_wait = 0; b_wait = 0;
    check_reset_outputs("midrst");
    clear_counters();
    src_q.push_back(beat_t'(32'h6001));
    src_q.push_back(beat_t'(32'h6002));
    request(32'h0000_6000, 6'd1, 3'd5);
    wait_finish(1, "t6_finish_seen");
    check("t6_awaddr", last_awaddr, 32'h6000);
    check("t6_w_beats", w_hs_count, 2);
    check("t6_wlast_count", wlast_count, 1);
    check("t6_last_wdata", last_wdata, beat_t'(32'h6002));
    check("t6_beat_id", axi_wr_beat_id, 2);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_tensor_wr.md
Name:
axi_tensor_wr

Overview:
- AXI4-Full write master (AW/W/B subset) for the tensorcore result write-back path; the write-direction counterpart of the tensorcore read adapter.
- Accepts one burst request at a time from the tensorcore: base address, beat count and beat size.
- Buffers the write data stream in a small FIFO, issues AW and then W beats with wlast, and waits for B.
- Returns a one-cycle finish pulse and a running beat count to the tensorcore.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 256, AXI/tensorcore data width; power of 2, 32..1024.
- FIFO_DEPTH, 4, write-data buffer entries; power of 2, ≥2.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- m_axi_awaddr  out  ADDR_WIDTH  burst base address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize  out  3  beat size.
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  DATA_WIDTH  write data.
- m_axi_wstrb  out  DATA_WIDTH/8  byte strobes.
- m_axi_wlast  out  1  last beat.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.
- axi_wr_BASE  in  32  request base address.
- axi_wr_burst_num  in  6  beats-1.
- axi_wr_burst_size  in  3  beat size.
- axi_wr_request_valid  in  1  request strobe.
- axi_wr_request_ready  out  1  request accepted when high with valid.
- axi_wr_data  in  DATA_WIDTH  write data beat.
- axi_wr_data_valid  in  1  data beat valid.
- axi_wr_data_ready  out  1  data beat accepted.
- axi_wr_finish  out  1  one-cycle pulse on B handshake.
- axi_wr_beat_id  out  32  W beats completed in current burst.
- axi_wr_busy  out  1  state≠IDLE.
- axi_wr_err  out  1  sticky bad-response flag (see Optional Feature).

Behaviour:
- Reset (areset=1 at posedge):
  - State goes to IDLE; FIFO flushed; all counters cleared.
  - All outputs 0, except awburst=2'b01 and request_ready=1.
  - Reset mid-burst abandons the AXI transaction; the slave is reset together with this block.
- FSM states IDLE, ADDR, DATA, RESP.
- IDLE:
  - request_ready=1.
  - On valid&ready: latch awaddr=BASE, awlen={2'b0,burst_num}, awsize=burst_size.
  - Clear in_cnt, out_cnt, beat_id, err; go to ADDR next cycle.
- ADDR:
  - awvalid=1; AW fields held stable until awready.
  - On awready: awvalid drops next cycle; go to DATA.
- DATA:
  - wvalid = FIFO not empty; wdata = FIFO head; wstrb all ones.
  - wlast = (out_cnt==awlen).
  - On wvalid&wready: pop, out_cnt++, beat_id++.
  - The handshake of the last beat moves the FSM to RESP.
- RESP:
  - bready=1.
  - On bvalid: finish=1 for exactly one cycle and return to IDLE.
  - beat_id holds its value until the next request is accepted.
- Data intake:
  - data_ready = (state ADDR or DATA) && FIFO not full && in_cnt ≤ awlen.
  - Data may be pushed before the AW handshake.
  - Beats beyond awlen+1 are not accepted.
- No W beat is issued before the AW handshake completes.
- FIFO:
  - Push and pop in the same cycle are allowed when 0<count<FIFO_DEPTH.
  - Push is refused when full, with no bypass; empty→wvalid=0.
- request_ready=0 in ADDR/DATA/RESP; requests presented then are ignored, not queued.
- awlen counts beats-1, so burst_num=0 gives a single beat. Counters are 8-bit, beat_id 32-bit, with no wrap within a burst.

Optional Feature:
- AXI_WR_RESP_CHECK_EN defined:
  - axi_wr_err sets on B handshake with bresp≠2'b00.
  - It stays set until the next request is accepted.
- Not defined:
  - axi_wr_err tied 0; bresp ignored.
  - finish behaviour is unchanged in both builds.

Test Plan:
- Single beat: BASE=0x1000, burst_num=0, size=5, data 0xA5.. → awaddr=0x1000, awlen=0, awsize=5, one W with wlast=1, wstrb all ones. bresp=0 → finish one cycle, beat_id=1.
- 16 beats (burst_num=15), wready toggling every cycle → 16 W beats in push order, wlast only on beat 16, data_ready low while FIFO holds 4, beat_id=16.
- awready delayed 10 cycles while data_valid=1 → exactly 4 beats accepted, wvalid=0 until the AW handshake, awaddr/awlen stable throughout.
- bvalid delayed 5 cycles; new request asserted during RESP → request_ready=0 until the cycle after the finish pulse, then accepted.
- bresp=2'b10 with AXI_WR_RESP_CHECK_EN → err=1 after B, cleared on the next request accept. Without the macro → err=0.
- areset pulsed after 3 of 8 beats → next cycle IDLE, all outputs at reset values, FIFO empty. A following 2-beat request completes normally.
